// File: rtl/crc_frame_check.sv
// Receive-side CRC checker: divides a framed byte stream (payload || CRC16, high
// byte first) bit-serially by POLY and reports pass/fail, remainder and length.
module crc_frame_check #(
  parameter logic [16:0] POLY    = 17'h11021,
  parameter logic [15:0] INIT    = 16'h0000,
  parameter int unsigned MIN_LEN = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        last_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        crc_ok_o,
  output logic        crc_err_o,
  output logic [15:0] rem_o,
  output logic [15:0] len_o
);

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
  localparam logic [15:0] LEN_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  byte_q;
  logic        last_q;
  logic [2:0]  bit_idx;
  logic [15:0] rem;
  logic [15:0] cnt;
  logic [15:0] rem_next;
  logic        accept;
  logic        frame_ok;

  assign accept   = valid_i && ready_o;
  assign frame_ok = (rem == '0) && (cnt >= MIN_LEN16);

  // One step of augmented long division; the feedback bit is the x^16 term.
  always_comb begin
    rem_next = {rem[14:0], byte_q[bit_idx]};
    if (rem[15]) begin
      rem_next = rem_next ^ POLY[15:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      byte_q    <= '0;
      last_q    <= 1'b0;
      bit_idx   <= '0;
      rem       <= INIT;
      cnt       <= '0;
      ready_o   <= 1'b1;
      done_o    <= 1'b0;
      crc_ok_o  <= 1'b0;
      crc_err_o <= 1'b0;
      rem_o     <= '0;
      len_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (accept) begin
            byte_q  <= data_i;
            last_q  <= last_i;
            bit_idx <= 3'd7;
            if (cnt != LEN_MAX) begin
              cnt <= cnt + 16'd1;
            end
            ready_o <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          rem     <= rem_next;
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) begin
            if (last_q) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              ready_o <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        DONE: begin
          done_o    <= 1'b0;
          crc_ok_o  <= frame_ok;
          crc_err_o <= !frame_ok;
          rem_o     <= rem;
          len_o     <= cnt;
          rem       <= INIT;
          cnt       <= '0;
          ready_o   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_check.sv
// Randomized bench for crc_frame_check: a cycle-level timing model plus a
// bit-array long-division reference, compared against the DUT every cycle.
module tb_crc_frame_check;

  localparam logic [16:0] POLY    = 17'h11021;
  localparam logic [15:0] INIT    = 16'h0000;
  localparam int unsigned MIN_LEN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = '0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready, done, crc_ok, crc_err;
  logic [15:0] rem, len;

  crc_frame_check #(.POLY(POLY), .INIT(INIT), .MIN_LEN(MIN_LEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready), .done_o(done), .crc_ok_o(crc_ok), .crc_err_o(crc_err),
    .rem_o(rem), .len_o(len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Remainder of (INIT * x^n + M(x)) mod POLY by textbook long division on a bit array.
  function automatic logic [15:0] ref_rem(input logic [7:0] m[$]);
    bit          b[];
    int unsigned n;
    logic [15:0] r;
    n = 16 + 8 * m.size();
    b = new[n];
    for (int unsigned i = 0; i < 16; i++) b[i] = INIT[15-i];
    for (int unsigned k = 0; k < m.size(); k++)
      for (int unsigned j = 0; j < 8; j++) b[16 + 8*k + j] = m[k][7-j];
    for (int unsigned i = 0; i + 16 < n; i++)
      if (b[i])
        for (int unsigned j = 0; j < 17; j++) b[i+j] = b[i+j] ^ POLY[16-j];
    for (int unsigned i = 0; i < 16; i++) r[15-i] = b[n-16+i];
    return r;
  endfunction

  // Timing/result model: in cycle c the DUT is ready iff c >= free_at,
  // pulses done iff c == done_at, and shows the held result otherwise.
  longint      cyc = 0;
  longint      free_at = 0;
  longint      done_at = -1;
  logic [7:0]  frame_q[$];
  logic [15:0] pend_rem, pend_len, exp_rem, exp_len;
  logic        pend_ok, exp_ok, exp_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; free_at = 0; done_at = -1;
      frame_q.delete();
      exp_ok = 0; exp_err = 0; exp_rem = '0; exp_len = '0;
    end else begin
      if (cyc == done_at) begin
        exp_ok = pend_ok; exp_err = !pend_ok; exp_rem = pend_rem; exp_len = pend_len;
      end
      if (valid && cyc >= free_at) begin
        frame_q.push_back(data);
        if (last) begin
          pend_rem = ref_rem(frame_q);
          pend_len = (frame_q.size() > 65535) ? 16'hFFFF : 16'(frame_q.size());
          pend_ok  = (pend_rem == 16'h0000) && (frame_q.size() >= MIN_LEN);
          done_at  = cyc + 9;
          free_at  = cyc + 10;
          frame_q.delete();
        end else begin
          free_at = cyc + 9;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", ready, 1); chk("rst_done", done, 0);
      chk("rst_ok", crc_ok, 0);   chk("rst_err", crc_err, 0);
      chk("rst_rem", rem, 0);     chk("rst_len", len, 0);
    end else begin
      chk("ready", ready, cyc >= free_at);
      chk("done", done, cyc == done_at);
      chk("crc_ok", crc_ok, exp_ok);
      chk("crc_err", crc_err, exp_err);
      chk("rem", rem, exp_rem);
      chk("len", len, exp_len);
    end
  end

  // Present a byte once ready is seen; while busy, drive garbage (valid held if hold).
  task automatic send(input logic [7:0] b, input logic l, input bit hold, input int unsigned gap);
    int unsigned waited = 0;
    repeat (gap) begin
      @(negedge clk); valid = 1'b0; data = 8'($urandom); last = 1'($urandom);
    end
    forever begin
      @(negedge clk);
      if (ready) begin
        data = b; last = l; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = hold; data = 8'($urandom); last = 1'($urandom);
        return;
      end
      valid = hold ? 1'b1 : 1'($urandom); data = 8'($urandom); last = 1'($urandom);
      waited++;
      if (waited > 40) begin
        chk("ready_timeout", 0, 1);
        valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] q[$], input bit hold, input int unsigned gap_max);
    for (int unsigned i = 0; i < q.size(); i++)
      send(q[i], i == q.size() - 1, hold, $urandom_range(gap_max));
    valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic ok, input logic [15:0] r,
                               input logic [15:0] l);
    int unsigned waited = 0;
    while (done !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 40) begin
        chk({name, "_done_timeout"}, 0, 1);
        return;
      end
    end
    @(negedge clk);
    chk({name, "_ok"}, crc_ok, ok);
    chk({name, "_err"}, crc_err, !ok);
    chk({name, "_rem"}, r == rem ? 32'(r) : 32'(rem), 32'(r));
    chk({name, "_len"}, len, l);
  endtask

  initial begin
    logic [7:0] good[$], bad[$], aug[$], shrt[$], hi[$], pl[$];
    logic [15:0] c;
    int unsigned ndone;
    good = '{8'h48, 8'h69, 8'h21, 8'h31, 8'hFD};
    bad  = '{8'h48, 8'h69, 8'h21, 8'h31, 8'hFC};
    aug  = '{8'h48, 8'h69, 8'h21, 8'h00, 8'h00};
    shrt = '{8'h00, 8'h00};
    hi   = '{8'h48, 8'h69, 8'h21};

    chk("model_good", ref_rem(good), 16'h0000);
    chk("model_aug", ref_rem(aug), 16'h31FD);
    chk("model_bad", ref_rem(bad), 16'h0001);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send_frame(good, 1'b1, 0);
    expect_result("good_held_valid", 1'b1, 16'h0000, 16'd5);
    send_frame(bad, 1'b0, 2);
    expect_result("corrupt_lsb", 1'b0, 16'h0001, 16'd5);
    send_frame(aug, 1'b0, 1);
    expect_result("zero_aug", 1'b0, 16'h31FD, 16'd5);
    send_frame(shrt, 1'b1, 0);
    expect_result("short", 1'b0, 16'h0000, 16'd2);
    send_frame('{8'h00}, 1'b0, 0);
    expect_result("single", 1'b0, 16'h0000, 16'd1);

    // Reset in the middle of a frame: the partial frame must vanish.
    send(good[0], 1'b0, 1'b0, 0);
    send(good[1], 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_spurious_done", ndone, 0);
    send_frame(good, 1'b0, 1);
    expect_result("after_reset", 1'b1, 16'h0000, 16'd5);

    // Random frames: mostly valid codewords, some random tails.
    for (int unsigned f = 0; f < 40; f++) begin
      pl.delete();
      repeat ($urandom_range(1, 8)) pl.push_back(8'($urandom));
      if ($urandom_range(9) < 7) begin
        pl.push_back(8'h00); pl.push_back(8'h00);
        c = ref_rem(pl);
        pl[pl.size()-2] = c[15:8];
        pl[pl.size()-1] = c[7:0];
      end
      send_frame(pl, 1'($urandom), $urandom_range(3));
      repeat ($urandom_range(12)) @(negedge clk);
    end
    send_frame(hi, 1'b0, 0);
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc_frame_check.md
# crc_frame_check

Receive-side CRC checker for the UART link. Consumes a framed byte stream (payload followed by its 16-bit CRC, high byte first) as produced by the transmit-side checksum generator. Divides the whole frame bit-serially by the generator polynomial and reports pass/fail, the final remainder and the frame length. Sits between the UART RX byte deframer and the packet consumer.

## Interface

Parameters:
- POLY, 17'h11021, generator polynomial including the x^16 term (same mask format as the generator's mask_i); bit 16 must be 1.
- INIT, 16'h0000, remainder preset at reset and at the start of each frame.
- MIN_LEN, 3, minimum legal frame length in bytes (CRC included); shorter frames are failed.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  8  received byte, MSB shifted first.
- valid_i  in  1  data_i valid.
- last_i  in  1  qualifies data_i as the final byte (CRC low byte) of the frame.
- ready_o  out  1  byte accepted when valid_i && ready_o.
- done_o  out  1  one-cycle pulse: frame result valid.
- crc_ok_o  out  1  remainder == 0 and length >= MIN_LEN; held until next done_o.
- crc_err_o  out  1  complement of crc_ok_o while a result is held; 0 before the first frame.
- rem_o  out  16  final remainder of the last frame; held until next done_o.
- len_o  out  16  byte count of the last frame, saturating at 16'hFFFF; held until next done_o.

## Operation

- Remainder update per bit b (augmented long division): fb = rem[15]; rem <= {rem[14:0], b} ^ (fb ? POLY[15:0] : 16'h0).
- A valid codeword (message || CRC computed with the same POLY/INIT) leaves rem == 0.
- FSM states:
  - IDLE: ready_o = 1. On handshake, latch the byte and last_i, increment the frame byte counter (saturating), go to SHIFT with bit index 7.
  - SHIFT: ready_o = 0. Each cycle, apply one bit of the latched byte, MSB first. Bit index 0 → go to IDLE if the latched last is 0, else go to DONE.
  - DONE: ready_o = 0. Pulse done_o. Load crc_ok_o, crc_err_o, rem_o and len_o. Reset the working remainder to INIT and the counter to 0. Go to IDLE.
- valid_i, data_i and last_i are ignored outside IDLE; the upstream block holds the byte until ready_o.
- Any byte count is accepted. Frames with len < MIN_LEN report crc_err_o = 1 even if rem == 0.
- The working remainder and counter carry across bytes until last_i; there is no timeout and no abort.

## Timing

- Reset (asynchronous assert, synchronous-to-clock deassert upstream):
  - state = IDLE, ready_o = 1, done_o = 0.
  - crc_ok_o = 0, crc_err_o = 0, rem_o = 0, len_o = 0.
  - Working remainder = INIT, counter = 0.
- Reset mid-frame discards the partial frame; no done_o is produced for it.
- Byte accepted at cycle T: shift cycles are T+1..T+8, and ready_o is high again at T+9.
  - Throughput is 1 byte per 9 cycles.
  - Back-to-back valid_i is accepted at T+9.
- For a last byte accepted at T: the state is DONE at T+9, and done_o is high during T+9.
  - Outputs update on the T+9→T+10 edge.
  - ready_o returns at T+10.
- Counter saturation: the 65536th and later bytes leave len at 16'hFFFF; the CRC still covers all bytes.
- A single-byte frame (last_i on the first byte) goes through DONE normally and fails the MIN_LEN check.

## Test plan

- Good frame: bytes 48,69,21,31,FD (hex), last on FD → single done_o, crc_ok_o = 1, rem_o = 0000, len_o = 5.
- Corrupt CRC LSB: bytes 48,69,21,31,FC → crc_err_o = 1, rem_o = 0001, len_o = 5.
- Zero-augmented message: bytes 48,69,21,00,00 → crc_err_o = 1, rem_o = 31FD, which equals the generator output for "Hi!".
- Handshake and cycle check: valid_i held high continuously for the good frame.
  - ready_o is low exactly 8 cycles after each accept.
  - done_o rises 9 cycles after the last accept.
  - data_i changes during SHIFT do not affect rem_o.
- Short frame: bytes 00,00 with last → rem_o = 0000 but crc_err_o = 1, len_o = 2.
- Reset mid-frame: assert rst_ni low after 2 bytes of the good frame, then send the full good frame → no spurious done_o; one done_o with crc_ok_o = 1, len_o = 5.
